jam_eval_sched: RTL

- Sequencer between a permutation generator and the shared cost ROM in the job-assignment design.
- Accepts one candidate worker-to-job assignment per valid/ready handshake, walks the cost ROM (W,J) for all workers, and accumulates the total.
- Optionally aborts a candidate early when its partial sum already exceeds the best total.
- Maintains MinCost/MatchCount and raises Valid after the last candidate.

---
 rtl/jam_pkg.sv | 23 ++
 rtl/jam_min_tracker.sv | 32 +++
 rtl/jam_eval_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared constants, state encoding and perm field helper for the
// job-assignment candidate evaluator.
package jam_pkg;
  localparam int N_WORKER = 8;
  localparam int IDX_W    = 3;
  localparam int COST_W   = 7;
  localparam int SUM_W    = 10;
  localparam int PERM_W   = N_WORKER * IDX_W;

  localparam logic [SUM_W-1:0] MIN_INIT = 10'd1023;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ISSUE   = 3'd1;
  localparam state_t S_DRAIN   = 3'd2;
  localparam state_t S_COMPARE = 3'd3;
  localparam state_t S_DONE    = 3'd4;

  function automatic logic [IDX_W-1:0] perm_job(input logic [PERM_W-1:0] perm,
                                                input logic [IDX_W-1:0]  k);
    return perm[k*IDX_W +: IDX_W];
  endfunction
endpackage

// File: rtl/jam_min_tracker.sv
// Best-total tracker: keeps the minimum completed sum and how many
// candidates reached it (count saturates at 15).
module jam_min_tracker
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_upd,
  input  logic [SUM_W-1:0] i_sum,
  output logic [SUM_W-1:0] o_min,
  output logic [3:0]       o_cnt
);
  logic [SUM_W-1:0] r_min;
  logic [3:0]       r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_min <= MIN_INIT;
      r_cnt <= 4'd0;
    end else if (i_upd) begin
      if (i_sum < r_min) begin
        r_min <= i_sum;
        r_cnt <= 4'd1;
      end else if (i_sum == r_min && r_cnt != 4'd15) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_min = r_min;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/jam_eval_sched.sv
// Walks the cost ROM for one latched candidate assignment, accumulates
// its total (with optional early abort) and feeds the min tracker.
module jam_eval_sched
  import jam_pkg::*;
#(
  parameter bit PRUNE_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              perm_valid,
  output logic              perm_ready,
  input  logic [PERM_W-1:0] perm_data,
  input  logic              perm_last,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [3:0]        MatchCount,
  output logic [SUM_W-1:0]  MinCost,
  output logic              Valid,
  output logic [15:0]       pruned_cnt
);
  state_t            r_state;
  logic [IDX_W-1:0]  r_k;
  logic [PERM_W-1:0] r_perm;
  logic              r_last;
  logic [SUM_W-1:0]  r_acc;
  logic [15:0]       r_pruned;

  logic              w_take;
  logic              w_add;
  logic              w_prune;
  logic [SUM_W-1:0]  w_sum;

  assign perm_ready = (r_state == S_IDLE);
  assign Valid      = (r_state == S_DONE);
  assign pruned_cnt = r_pruned;
  assign w_take     = perm_valid && perm_ready;

  // ROM data lags the address by one cycle, so the add for address k-1
  // lands while address k is issued, and the last one lands in DRAIN.
  assign w_add   = (r_state == S_ISSUE && r_k != '0) || (r_state == S_DRAIN);
  assign w_sum   = r_acc + {{(SUM_W-COST_W){1'b0}}, Cost};
  assign w_prune = PRUNE_EN && w_add && (w_sum > MinCost);

  // An aborting candidate stops presenting addresses in the detect cycle.
  assign W = (r_state == S_ISSUE && !w_prune) ? r_k : '0;
  assign J = (r_state == S_ISSUE && !w_prune) ? perm_job(r_perm, r_k) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_perm   <= '0;
      r_last   <= 1'b0;
      r_acc    <= '0;
      r_pruned <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc <= '0;
          if (w_take) begin
            r_perm  <= perm_data;
            r_last  <= perm_last;
            r_k     <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_add) r_acc <= w_sum;
          if (w_prune) begin
            r_pruned <= r_pruned + 16'd1;
            r_state  <= r_last ? S_DONE : S_IDLE;
          end else begin
            r_k <= r_k + 3'd1;
            if (r_k == 3'(N_WORKER-1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_acc <= w_sum;
          if (w_prune) begin
            r_pruned <= r_pruned + 16'd1;
            r_state  <= r_last ? S_DONE : S_IDLE;
          end else begin
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: r_state <= r_last ? S_DONE : S_IDLE;
        S_DONE:    r_state <= S_DONE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  jam_min_tracker u_min (
    .CLK   (CLK),
    .RST   (RST),
    .i_upd (r_state == S_COMPARE),
    .i_sum (r_acc),
    .o_min (MinCost),
    .o_cnt (MatchCount)
  );
endmodule
